q_learning: RTL and testbench
=============================

# q_learning

Single-step Q-learning update engine for the tic-tac-toe agent. It holds a hashed Q-table of signed Q8.8 values indexed by board state and action. On each new set of inputs it performs one Bellman update: Q ← Q + α·(r + γ·max Q(s′,·) − Q). It writes the result back to the table and presents it on `Q_new`. It sits between the game controller, which supplies state, action and reward, and the policy logic, which consumes `Q_new`.

## Interface
- `HASH_W`, 8: width of the state hash; table depth is 2^(HASH_W+4).
- `clock`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `action`  in  4: cell index 0..8; values 9..15 are invalid.
- `state`  in  18: current board, 9 cells × 2 bits, cell k at bits [2k+1:2k].
- `next_state`  in  18: board after `action`.
- `reward`  in  16: signed Q8.8.
- `gamma`  in  16: discount, signed Q8.8.
- `alfa`  in  16: learning rate, signed Q8.8.
- `Q_new`  out  16: signed Q8.8, last updated Q(s,a), registered.

## Operation
- Address is {hash(s), a}. hash = XOR-fold of the 18-bit state into HASH_W-bit chunks, last chunk zero-padded. Collisions alias by design.
- Trigger: in IDLE, any difference between {action, state, next_state, reward, gamma, alfa} and the last captured copy starts an update. The first IDLE cycle after CLEAR always triggers. Inputs are latched at the trigger edge; later input changes are ignored until the FSM returns to IDLE.
- FSM states:
  - CLEAR: writes 0 to every table address, one per cycle, then goes to IDLE.
  - IDLE: waits for a trigger.
  - RD_SA: reads Q(s,a).
  - SCAN: reads Q(s′,i) for i = 0..8.
  - WAIT: absorbs read latency.
  - CALC: performs the arithmetic.
  - WRITE: writes the table and `Q_new`, then returns to IDLE.
- Invalid action (≥9): FSM goes IDLE→IDLE; no table write; `Q_new` holds.
- Arithmetic:
  - maxQ is the signed maximum over the 9 values.
  - t = reward + ((gamma·maxQ) >>> 8) − Q. Products are 32-bit signed. `>>>` is an arithmetic shift, so results floor.
  - d = (alfa·t) >>> 8.
  - Q_new = Q + d, computed at 18-bit intermediate width, then narrowed to 16 bits (see Configuration).
- Table is single-port: exactly one read or one write per cycle.

## Timing
- Reset: `Q_new` = 0, FSM = CLEAR, clear counter = 0, captured inputs = 0.
- CLEAR lasts 2^(HASH_W+4) cycles (4096 by default).
- Asserting reset mid-operation, including mid-CLEAR, aborts the operation and restarts CLEAR from address 0.
- Capture at edge 0.
- RD_SA issues its read at edge 1.
- SCAN issues reads at edges 2..10.
- Synchronous read data returns one edge later, so the last datum lands at edge 11 (WAIT).
- CALC registers the result at edge 12.
- WRITE updates the table and `Q_new` at edge 13.
- Next trigger is possible at edge 14.
- If a = i and s′ hashes to s, the scan returns the pre-update value.

## Configuration
- `Q_LEARNING_SAT_EN` defined: the final sum and t saturate to [0x8000, 0x7FFF].
- Undefined: both wrap (two's-complement truncation to 16 bits).

## Structure
- Package `q_learning_pkg` holds:
  - FRAC_W = 8, NUM_ACTIONS = 9, STATE_W = 18, Q_W = 16;
  - the FSM state enum;
  - the `hash_fold` and `sat16` functions.
- Sub-module `q_table`: single-port synchronous RAM, Q_W wide, depth 2^(HASH_W+4), one-cycle read latency, no reset.
- FSM and datapath stay in `q_learning`.

## Test plan
- Reset, wait for CLEAR, then apply reward = 2, gamma = 2, alfa = 2, action = 2, state = 0, next_state = 3 → `Q_new` = 0x0000 at edge 13 after capture; d floors to 0.
- After clear: reward = 0x0100, gamma = 0x0080, alfa = 0x0100, a = 4 → `Q_new` = 0x0100. Repeat with reward = 0x0001 on the same s,a, next_state = 0 → t = 0x0001 − 0x0100, `Q_new` = 0x0001.
- Seed Q(s′,7) = 0x0200 via a prior update. Then reward = 0, gamma = 0x0080, alfa = 0x0100 → `Q_new` = 0x0100 (maxQ picked from action 7).
- With `Q_LEARNING_SAT_EN`: Q = 0x7F00, reward = 0x7FFF, alfa = 0x0100 → `Q_new` = 0x7FFF. Without the macro → the wrapped value.
- action = 12 → no write, `Q_new` unchanged, FSM back in IDLE next cycle.
- Reset pulse at cycle 6 of an update → `Q_new` = 0 immediately; a fresh CLEAR follows; the next update starts only after the full clear.

Source files
------------

// File: rtl/q_learning_pkg.sv
// Shared constants, FSM encoding and helpers for the Q-learning engine.
// Holds the state-hash fold and the 16-bit saturation helper.
package q_learning_pkg;

   localparam int FRAC_W      = 8;
   localparam int NUM_ACTIONS = 9;
   localparam int STATE_W     = 18;
   localparam int Q_W         = 16;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_RD_SA,
      ST_SCAN,
      ST_WAIT,
      ST_CALC,
      ST_WRITE
   } fsm_e;

   // XOR-fold the board into hw-bit chunks; the short last chunk is
   // implicitly zero-padded. Only the low hw bits are meaningful.
   function automatic logic [15:0] hash_fold(
      input logic [STATE_W-1:0] s,
      input int                 hw
   );
      logic [15:0] h;
      logic [3:0]  k;
      h = '0;
      for (int i = 0; i < STATE_W; i++) begin
         k    = 4'(i % hw);
         h[k] = h[k] ^ s[i];
      end
      return h;
   endfunction

   function automatic logic [Q_W-1:0] sat16(input logic signed [31:0] x);
      if (x > 32'sd32767)
         return 16'h7FFF;
      else if (x < -32'sd32768)
         return 16'h8000;
      else
         return x[15:0];
   endfunction

endpackage

// File: rtl/q_table.sv
// Single-port synchronous Q-table: one read or one write per cycle,
// one-cycle read latency, contents not reset.
module q_table
   import q_learning_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic           clock,
   input  logic           we_i,
   input  logic           re_i,
   input  logic [AW-1:0]  addr_i,
   input  logic [Q_W-1:0] wdata_i,
   output logic [Q_W-1:0] rdata_o
);

   logic [Q_W-1:0] mem_q [2**AW];

   // Write has priority; a read registers the addressed word.
   always_ff @(posedge clock) begin
      if (we_i)
         mem_q[addr_i] <= wdata_i;
      else if (re_i)
         rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/q_learning.sv
// Single-step Bellman update engine over a hashed Q8.8 Q-table.
// Define Q_LEARNING_SAT_EN to saturate t and the final sum instead of wrapping.
module q_learning
   import q_learning_pkg::*;
#(
   parameter int HASH_W = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [3:0]            action,
   input  logic [STATE_W-1:0]    state,
   input  logic [STATE_W-1:0]    next_state,
   input  logic [Q_W-1:0]        reward,
   input  logic [Q_W-1:0]        gamma,
   input  logic [Q_W-1:0]        alfa,
   output logic [Q_W-1:0]        Q_new
);

   localparam int AW    = HASH_W + 4;
   localparam int CAP_W = 4 + 2*STATE_W + 3*Q_W;

   fsm_e             fsm_q, fsm_d;
   logic [AW-1:0]    clr_q, clr_d;
   logic             force_q, force_d;
   logic [CAP_W-1:0] cap_q, cap_d;
   logic [3:0]       idx_q, idx_d;

   logic             rd_sa_q, rd_scan_q, rd_first_q;
   logic [Q_W-1:0]   qsa_q, max_q, res_q, q_new_q;

   logic [CAP_W-1:0]   in_vec;
   logic [3:0]         act_c;
   logic [STATE_W-1:0] s_c, sn_c;
   logic [Q_W-1:0]     rew_c, gam_c, alf_c;
   logic               trig;

   logic [15:0]        hs_full, hn_full;
   logic [AW-1:0]      sa_addr, scan_addr;

   logic               we, re;
   logic [AW-1:0]      addr;
   logic [Q_W-1:0]     wdata, rdata;

   logic signed [31:0] gprod, t_wide, dprod, d;
   logic [Q_W-1:0]     t16, res_d;
   logic signed [17:0] sum18;
   logic               unused_ok;

   assign in_vec = {action, state, next_state, reward, gamma, alfa};
   assign {act_c, s_c, sn_c, rew_c, gam_c, alf_c} = cap_q;
   assign trig   = force_q || (in_vec != cap_q);

   assign hs_full   = hash_fold(s_c, HASH_W);
   assign hn_full   = hash_fold(sn_c, HASH_W);
   assign sa_addr   = {hs_full[HASH_W-1:0], act_c};
   assign scan_addr = {hn_full[HASH_W-1:0], idx_q};

   assign Q_new = q_new_q;

   q_table #(.AW(AW)) u_table (
      .clock   (clock),
      .we_i    (we),
      .re_i    (re),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rdata_o (rdata)
   );

   // Next-state logic, input capture and table port control.
   always_comb begin
      fsm_d   = fsm_q;
      clr_d   = clr_q;
      force_d = force_q;
      cap_d   = cap_q;
      idx_d   = idx_q;
      we      = 1'b0;
      re      = 1'b0;
      addr    = '0;
      wdata   = '0;
      unique case (fsm_q)
         ST_CLEAR: begin
            we    = 1'b1;
            addr  = clr_q;
            clr_d = clr_q + AW'(1);
            if (clr_q == '1) begin
               fsm_d   = ST_IDLE;
               force_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (trig) begin
               cap_d   = in_vec;
               force_d = 1'b0;
               if (action < 4'(NUM_ACTIONS))
                  fsm_d = ST_RD_SA;
            end
         end
         ST_RD_SA: begin
            re    = 1'b1;
            addr  = sa_addr;
            idx_d = '0;
            fsm_d = ST_SCAN;
         end
         ST_SCAN: begin
            re    = 1'b1;
            addr  = scan_addr;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'(NUM_ACTIONS-1))
               fsm_d = ST_WAIT;
         end
         ST_WAIT:  fsm_d = ST_CALC;
         ST_CALC:  fsm_d = ST_WRITE;
         ST_WRITE: begin
            we    = 1'b1;
            addr  = sa_addr;
            wdata = res_q;
            fsm_d = ST_IDLE;
         end
         default:  fsm_d = ST_CLEAR;
      endcase
   end

   // Bellman arithmetic on the gathered Q(s,a) and max Q(s',.).
   always_comb begin
      gprod  = 32'($signed(gam_c)) * 32'($signed(max_q));
      t_wide = 32'($signed(rew_c)) + (gprod >>> FRAC_W)
             - 32'($signed(qsa_q));
`ifdef Q_LEARNING_SAT_EN
      t16    = sat16(t_wide);
`else
      t16    = t_wide[15:0];
`endif
      dprod  = 32'($signed(alf_c)) * 32'($signed(t16));
      d      = dprod >>> FRAC_W;
      sum18  = 18'($signed(qsa_q)) + $signed(d[17:0]);
`ifdef Q_LEARNING_SAT_EN
      res_d  = sat16(32'(sum18));
`else
      res_d  = sum18[15:0];
`endif
   end

   assign unused_ok = ^{hs_full[15:HASH_W], hn_full[15:HASH_W],
                        d[31:18], t_wide[31:16], sum18[17:16]};

   // Control state registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q   <= ST_CLEAR;
         clr_q   <= '0;
         force_q <= 1'b0;
         cap_q   <= '0;
         idx_q   <= '0;
      end else begin
         fsm_q   <= fsm_d;
         clr_q   <= clr_d;
         force_q <= force_d;
         cap_q   <= cap_d;
         idx_q   <= idx_d;
      end
   end

   // Read-data steering, running max, result and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_sa_q    <= 1'b0;
         rd_scan_q  <= 1'b0;
         rd_first_q <= 1'b0;
         qsa_q      <= '0;
         max_q      <= '0;
         res_q      <= '0;
         q_new_q    <= '0;
      end else begin
         rd_sa_q    <= (fsm_q == ST_RD_SA);
         rd_scan_q  <= (fsm_q == ST_SCAN);
         rd_first_q <= (fsm_q == ST_SCAN) && (idx_q == 4'd0);
         if (rd_sa_q)
            qsa_q <= rdata;
         if (rd_scan_q &&
             (rd_first_q || ($signed(rdata) > $signed(max_q))))
            max_q <= rdata;
         if (fsm_q == ST_CALC)
            res_q <= res_d;
         if (fsm_q == ST_WRITE)
            q_new_q <= res_q;
      end
   end

endmodule

// File: tb/tb_q_learning.sv
// Directed self-checking bench for q_learning.
// Expected values are hand-computed Q8.8 Bellman results.
module tb_q_learning;
   import q_learning_pkg::*;

   logic               clock;
   logic               reset_n;
   logic [3:0]         action;
   logic [STATE_W-1:0] state, next_state;
   logic [Q_W-1:0]     reward, gamma, alfa;
   logic [Q_W-1:0]     Q_new;

   int n_chk  = 0;
   int n_pass = 0;
   logic [15:0] last_q;

`ifdef Q_LEARNING_SAT_EN
   localparam logic [15:0] EXP_OVF = 16'h7FFF;
`else
   localparam logic [15:0] EXP_OVF = 16'hFEFF;
`endif

   q_learning #(.HASH_W(8)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .action     (action),
      .state      (state),
      .next_state (next_state),
      .reward     (reward),
      .gamma      (gamma),
      .alfa       (alfa),
      .Q_new      (Q_new)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic drive(input logic [3:0] a, input logic [17:0] s,
                        input logic [17:0] sn, input logic [15:0] r,
                        input logic [15:0] g, input logic [15:0] al);
      action     = a;
      state      = s;
      next_state = sn;
      reward     = r;
      gamma      = g;
      alfa       = al;
   endtask

   // Called at a negedge with the FSM idle; the next posedge is the capture.
   task automatic run_update(input string tag, input logic [3:0] a,
                             input logic [17:0] s, input logic [17:0] sn,
                             input logic [15:0] r, input logic [15:0] g,
                             input logic [15:0] al, input logic [15:0] exp);
      drive(a, s, sn, r, g, al);
      repeat (13) @(posedge clock);
      #1 check({tag, "_e12"}, Q_new, last_q);
      @(posedge clock);
      #1 check({tag, "_e13"}, Q_new, exp);
      last_q = exp;
      @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0;
      drive(4'd15, '0, '0, '0, '0, '0);
      last_q = 16'h0000;
      #1 check("reset_q", Q_new, 16'h0000);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (4100) @(negedge clock);
      check("post_clear", Q_new, 16'h0000);

      run_update("floor0", 4'd2, 18'h0, 18'h3,
                 16'h0002, 16'h0002, 16'h0002, 16'h0000);
      run_update("basic", 4'd4, 18'h10, 18'h20,
                 16'h0100, 16'h0080, 16'h0100, 16'h0100);
      run_update("neg_t", 4'd4, 18'h10, 18'h0,
                 16'h0001, 16'h0080, 16'h0100, 16'h0001);
      run_update("seed7", 4'd7, 18'h40, 18'h50,
                 16'h0200, 16'h0000, 16'h0100, 16'h0200);
      run_update("maxq7", 4'd1, 18'h60, 18'h40,
                 16'h0000, 16'h0080, 16'h0100, 16'h0100);
      run_update("floor_neg", 4'd0, 18'h70, 18'h80,
                 16'hFFFF, 16'h0000, 16'h0080, 16'hFFFF);
      run_update("seed_big", 4'd3, 18'h90, 18'hA0,
                 16'h7F00, 16'h0000, 16'h0100, 16'h7F00);
      run_update("overflow", 4'd3, 18'h90, 18'h90,
                 16'h7FFF, 16'h0100, 16'h0100, EXP_OVF);
      run_update("signed_max", 4'd5, 18'hB0, 18'h70,
                 16'h0000, 16'h0100, 16'h0100, 16'h0000);

      // Invalid action: no update, then a valid one captured next cycle.
      drive(4'd12, 18'hC0, 18'hC0, 16'h1234, 16'h0100, 16'h0100);
      @(posedge clock);
      #1 check("inv_hold", Q_new, last_q);
      @(negedge clock);
      run_update("after_inv", 4'd4, 18'h10, 18'h20,
                 16'h0100, 16'h0000, 16'h0100, 16'h0100);

      // Input change mid-update is ignored, then triggers the next update.
      drive(4'd6, 18'hD0, 18'hE0, 16'h0100, 16'h0000, 16'h0100);
      repeat (3) @(posedge clock);
      #1 reward = 16'h0300;
      repeat (10) @(posedge clock);
      #1 check("latch_e12", Q_new, last_q);
      @(posedge clock);
      #1 check("latch_e13", Q_new, 16'h0100);
      repeat (13) @(posedge clock);
      #1 check("retrig_e26", Q_new, 16'h0100);
      @(posedge clock);
      #1 check("retrig_e27", Q_new, 16'h0300);
      last_q = 16'h0300;
      @(negedge clock);

      // Reset during an update, then a full clear before the next one.
      drive(4'd3, 18'h90, 18'hA0, 16'h0300, 16'h0000, 16'h0080);
      repeat (6) @(posedge clock);
      #2 reset_n = 1'b0;
      #1 check("rst_async", Q_new, 16'h0000);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2000) @(posedge clock);
      #1 check("mid_clear", Q_new, 16'h0000);
      repeat (2109) @(posedge clock);
      #1 check("clr_e12", Q_new, 16'h0000);
      @(posedge clock);
      #1 check("clr_e13", Q_new, 16'h0180);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
